// File: rtl/axi_read_reorder_buffer.sv
// AXI read reorder buffer: buffers out-of-order slave read data per ID
// and returns it to the master in AR acceptance order.
module axi_read_reorder_buffer #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int ID_WIDTH   = 4,
   parameter int DEPTH      = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [ADDR_WIDTH-1:0]     up_araddr,
   input  logic [ID_WIDTH-1:0]       up_arid,
   input  logic                      up_arvalid,
   output logic                      up_arready,
   output logic [ADDR_WIDTH-1:0]     dn_araddr,
   output logic [ID_WIDTH-1:0]       dn_arid,
   output logic                      dn_arvalid,
   input  logic                      dn_arready,
   input  logic [DATA_WIDTH-1:0]     dn_rdata,
   input  logic [ID_WIDTH-1:0]       dn_rid,
   input  logic                      dn_rvalid,
   output logic                      dn_rready,
   output logic [DATA_WIDTH-1:0]     up_rdata,
   output logic [ID_WIDTH-1:0]       up_rid,
   output logic                      up_rvalid,
   input  logic                      up_rready,
   output logic [$clog2(DEPTH):0]    outstanding,
   output logic                      id_error
);

   localparam int NSLOT = 2 ** ID_WIDTH;
   localparam int PW    = $clog2(DEPTH);
   localparam int CW    = PW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [ID_WIDTH-1:0]   fifo [DEPTH];
   logic [DATA_WIDTH-1:0] slot [NSLOT];
   logic [PW-1:0]         wptr, rptr;
   logic [CW-1:0]         cnt;
   logic [NSLOT-1:0]      pending, slot_valid;
   logic [NSLOT-1:0]      pend_n, sv_n;
   logic [ID_WIDTH-1:0]   head;
   logic                  accept_ok, ar_hs, r_in, r_good, pop;

   assign head      = fifo[rptr];
   assign accept_ok = (cnt < FULL) && !pending[up_arid];

   assign dn_araddr  = up_araddr;
   assign dn_arid    = up_arid;
   assign dn_arvalid = up_arvalid & accept_ok;
   assign up_arready = dn_arready & accept_ok;
   assign dn_rready  = !slot_valid[dn_rid];

   assign up_rvalid = (cnt != '0) && slot_valid[head];
   assign up_rid    = head;
   assign up_rdata  = slot[head];

   assign ar_hs  = dn_arvalid & dn_arready;
   assign r_in   = dn_rvalid & dn_rready;
   assign r_good = r_in & pending[dn_rid];
   assign pop    = up_rvalid & up_rready;

   assign outstanding = cnt;

   // Head slot is valid when popped, so it never collides with a new write.
   always_comb begin
      pend_n = pending;
      sv_n   = slot_valid;
      if (ar_hs)
         pend_n[up_arid] = 1'b1;
      if (r_good)
         sv_n[dn_rid] = 1'b1;
      if (pop) begin
         pend_n[head] = 1'b0;
         sv_n[head]   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr       <= '0;
         rptr       <= '0;
         cnt        <= '0;
         pending    <= '0;
         slot_valid <= '0;
         id_error   <= 1'b0;
      end else begin
         pending    <= pend_n;
         slot_valid <= sv_n;
         if (ar_hs)
            wptr <= wptr + 1'b1;
         if (pop)
            rptr <= rptr + 1'b1;
         case ({ar_hs, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
         if (r_in && !pending[dn_rid])
            id_error <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (ar_hs)
         fifo[wptr] <= up_arid;
      if (r_good)
         slot[dn_rid] <= dn_rdata;
   end

endmodule

// File: tb/tb_axi_read_reorder_buffer.sv
// Directed bench for axi_read_reorder_buffer: ordering, full/duplicate
// blocking, unknown-ID errors, backpressure hold and mid-run reset.
module tb_axi_read_reorder_buffer;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] up_araddr;
   logic [3:0]  up_arid;
   logic        up_arvalid;
   logic        up_arready;
   logic [31:0] dn_araddr;
   logic [3:0]  dn_arid;
   logic        dn_arvalid;
   logic        dn_arready;
   logic [31:0] dn_rdata;
   logic [3:0]  dn_rid;
   logic        dn_rvalid;
   logic        dn_rready;
   logic [31:0] up_rdata;
   logic [3:0]  up_rid;
   logic        up_rvalid;
   logic        up_rready;
   logic [3:0]  outstanding;
   logic        id_error;

   int checks = 0;
   int errors = 0;

   axi_read_reorder_buffer dut (
      .clk(clk), .rst(rst),
      .up_araddr(up_araddr), .up_arid(up_arid),
      .up_arvalid(up_arvalid), .up_arready(up_arready),
      .dn_araddr(dn_araddr), .dn_arid(dn_arid),
      .dn_arvalid(dn_arvalid), .dn_arready(dn_arready),
      .dn_rdata(dn_rdata), .dn_rid(dn_rid),
      .dn_rvalid(dn_rvalid), .dn_rready(dn_rready),
      .up_rdata(up_rdata), .up_rid(up_rid),
      .up_rvalid(up_rvalid), .up_rready(up_rready),
      .outstanding(outstanding), .id_error(id_error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs,
                      input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [3:0] id);
      up_arvalid = 1'b1;
      up_arid    = id;
      up_araddr  = 32'h1000 + {24'd0, id, 4'd0};
      #1;
      chk("ar_ready", up_arready, 1);
      chk("dn_arvalid", dn_arvalid, 1);
      chk("dn_araddr", dn_araddr, 32'h1000 + {24'd0, id, 4'd0});
      chk("dn_arid", dn_arid, id);
      tick();
      up_arvalid = 1'b0;
   endtask

   task automatic try_block(input logic [3:0] id);
      up_arvalid = 1'b1;
      up_arid    = id;
      #1;
      chk("ar_blocked", up_arready, 0);
      chk("dn_arvalid_blocked", dn_arvalid, 0);
      tick();
      up_arvalid = 1'b0;
   endtask

   task automatic resp(input logic [3:0] id, input logic [31:0] d);
      dn_rvalid = 1'b1;
      dn_rid    = id;
      dn_rdata  = d;
      #1;
      chk("dn_rready", dn_rready, 1);
      tick();
      dn_rvalid = 1'b0;
   endtask

   task automatic take(input logic [3:0] id, input logic [31:0] d);
      up_rready = 1'b1;
      #1;
      chk("up_rvalid", up_rvalid, 1);
      chk("up_rid", up_rid, id);
      chk("up_rdata", up_rdata, d);
      tick();
      up_rready = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      up_araddr = '0; up_arid = '0; up_arvalid = 1'b0;
      dn_arready = 1'b1;
      dn_rdata = '0; dn_rid = '0; dn_rvalid = 1'b0;
      up_rready = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      chk("rst_outstanding", outstanding, 0);
      chk("rst_up_rvalid", up_rvalid, 0);
      chk("rst_id_error", id_error, 0);
      chk("rst_dn_arvalid", dn_arvalid, 0);

      // Reverse-order responses come back in issue order
      issue(4'd1);
      issue(4'd2);
      issue(4'd3);
      chk("rev_outstanding", outstanding, 3);
      resp(4'd3, 32'hC);
      chk("rev_hold_head", up_rvalid, 0);
      resp(4'd2, 32'hB);
      chk("rev_hold_head2", up_rvalid, 0);
      resp(4'd1, 32'hA);
      take(4'd1, 32'hA);
      take(4'd2, 32'hB);
      take(4'd3, 32'hC);
      chk("rev_drained", outstanding, 0);
      chk("rev_empty", up_rvalid, 0);

      // Full: pop in the same cycle does not unblock AR
      for (int i = 0; i < 8; i++) issue(4'(i));
      chk("full_outstanding", outstanding, 8);
      resp(4'd0, 32'h100);
      up_arvalid = 1'b1;
      up_arid    = 4'd8;
      up_rready  = 1'b1;
      #1;
      chk("full_blocked", up_arready, 0);
      chk("full_pop_valid", up_rvalid, 1);
      chk("full_pop_rid", up_rid, 0);
      chk("full_pop_data", up_rdata, 32'h100);
      tick();
      up_rready = 1'b0;
      #1;
      chk("full_after_pop", outstanding, 7);
      chk("full_next_accept", up_arready, 1);
      tick();
      up_arvalid = 1'b0;
      chk("full_refill", outstanding, 8);
      for (int i = 1; i <= 8; i++) resp(4'(i), 32'h100 + i);
      for (int i = 1; i <= 8; i++) take(4'(i), 32'h100 + i);
      chk("full_drained", outstanding, 0);

      // Duplicate ID blocked until delivered, including the pop cycle
      issue(4'd5);
      try_block(4'd5);
      resp(4'd5, 32'h55);
      up_arvalid = 1'b1;
      up_arid    = 4'd5;
      up_rready  = 1'b1;
      #1;
      chk("dup_pop_valid", up_rvalid, 1);
      chk("dup_pop_blocked", up_arready, 0);
      tick();
      up_rready = 1'b0;
      #1;
      chk("dup_reaccept", up_arready, 1);
      tick();
      up_arvalid = 1'b0;
      resp(4'd5, 32'h56);
      take(4'd5, 32'h56);
      chk("dup_drained", outstanding, 0);

      // Response for an ID never issued
      issue(4'd2);
      dn_rvalid = 1'b1;
      dn_rid    = 4'd9;
      dn_rdata  = 32'hDEAD;
      #1;
      chk("bad_rready", dn_rready, 1);
      tick();
      dn_rvalid = 1'b0;
      chk("bad_id_error", id_error, 1);
      chk("bad_up_rvalid", up_rvalid, 0);
      chk("bad_outstanding", outstanding, 1);
      resp(4'd2, 32'h22);
      take(4'd2, 32'h22);
      chk("bad_sticky", id_error, 1);

      // Backpressure hold then back-to-back delivery
      issue(4'd3);
      issue(4'd4);
      issue(4'd6);
      resp(4'd6, 32'h666);
      resp(4'd4, 32'h444);
      resp(4'd3, 32'h333);
      for (int i = 0; i < 20; i++) begin
         chk("hold_valid", up_rvalid, 1);
         chk("hold_rid", up_rid, 3);
         chk("hold_data", up_rdata, 32'h333);
         tick();
      end
      up_rready = 1'b1;
      #1;
      chk("b2b_rid0", up_rid, 3);
      chk("b2b_data0", up_rdata, 32'h333);
      tick();
      chk("b2b_valid1", up_rvalid, 1);
      chk("b2b_rid1", up_rid, 4);
      chk("b2b_data1", up_rdata, 32'h444);
      tick();
      chk("b2b_valid2", up_rvalid, 1);
      chk("b2b_rid2", up_rid, 6);
      chk("b2b_data2", up_rdata, 32'h666);
      tick();
      up_rready = 1'b0;
      chk("b2b_empty", up_rvalid, 0);
      chk("b2b_outstanding", outstanding, 0);

      // Reset with reads outstanding and one buffered
      issue(4'd7);
      issue(4'd8);
      issue(4'd9);
      resp(4'd7, 32'h777);
      chk("pre_rst_valid", up_rvalid, 1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      chk("mrst_outstanding", outstanding, 0);
      chk("mrst_up_rvalid", up_rvalid, 0);
      chk("mrst_id_error", id_error, 0);
      issue(4'd1);
      chk("mrst_accept", outstanding, 1);
      chk("mrst_no_stale", up_rvalid, 0);
      resp(4'd1, 32'hAB);
      take(4'd1, 32'hAB);
      issue(4'd7);
      chk("mrst_slot_clear", up_rvalid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axi_read_reorder_buffer.md
AXI_READ_REORDER_BUFFER -- requirements
Module: axi_read_reorder_buffer

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address width.
REQ-002 Parameter DATA_WIDTH, default 32, read data width.
REQ-003 Parameter ID_WIDTH, default 4, transaction ID width; one storage slot per ID value (2**ID_WIDTH slots).
REQ-004 Parameter DEPTH, default 8, power of 2, maximum outstanding reads.
REQ-005 The block SHALL have one clock, clk; reset is rst, synchronous and active-high.
REQ-006 The block SHALL have these ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- up_araddr  in  ADDR_WIDTH  read address from master
- up_arid  in  ID_WIDTH  read ID from master
- up_arvalid  in  1  master address valid
- up_arready  out  1  address accepted
- dn_araddr  out  ADDR_WIDTH  read address to slave
- dn_arid  out  ID_WIDTH  read ID to slave
- dn_arvalid  out  1  address valid to slave
- dn_arready  in  1  slave address ready
- dn_rdata  in  DATA_WIDTH  read data from slave, any order
- dn_rid  in  ID_WIDTH  response ID from slave
- dn_rvalid  in  1  slave response valid
- dn_rready  out  1  response accepted
- up_rdata  out  DATA_WIDTH  read data to master, AR issue order
- up_rid  out  ID_WIDTH  response ID to master
- up_rvalid  out  1  response valid to master
- up_rready  in  1  master response ready
- outstanding  out  $clog2(DEPTH)+1  count of accepted, not yet delivered reads
- id_error  out  1  sticky: response received for an ID not outstanding

Function
REQ-007 The block SHALL sit between the master and the out-of-order slave and return read responses to the master in AR acceptance order.
REQ-008 The block SHALL compute accept_ok = (outstanding < DEPTH) and the ID up_arid is not already outstanding.
REQ-009 The block SHALL drive dn_araddr = up_araddr, dn_arid = up_arid, dn_arvalid = up_arvalid & accept_ok, and up_arready = dn_arready & accept_ok, all combinationally.
REQ-010 On an AR handshake (dn_arvalid & dn_arready), the block SHALL push arid into the order FIFO and set pending[arid].
REQ-011 The block SHALL drive dn_rready = !slot_valid[dn_rid] combinationally.
REQ-012 On dn_rvalid & dn_rready with pending[dn_rid] set, the block SHALL write dn_rdata to slot[dn_rid] and set slot_valid[dn_rid] at the next edge.
REQ-013 On dn_rvalid & dn_rready with pending[dn_rid] clear, the block SHALL discard the beat and set id_error (sticky until rst).
REQ-014 The block SHALL drive up_rvalid = FIFO non-empty & slot_valid[head], up_rid = head, and up_rdata = slot[head]; there is no same-cycle bypass, so minimum R-to-up latency is 1 cycle.
REQ-015 On up_rvalid & up_rready, the block SHALL pop the FIFO and clear slot_valid[head] and pending[head] at the next edge.
REQ-016 While up_rvalid is asserted and up_rready is low, the block SHALL hold up_rdata and up_rid stable.
REQ-017 outstanding SHALL increment on an AR handshake, decrement on an up R handshake, and stay unchanged when both happen in the same cycle.
REQ-018 When full (outstanding == DEPTH), AR SHALL be blocked even if a pop occurs in the same cycle; the AR is accepted on the next cycle.
REQ-019 An ID popped in cycle N SHALL be blocked for AR in cycle N and acceptable from N+1.
REQ-020 In the same cycle, a slot write and a pop of a different ID SHALL both take effect; a write to a slot awaiting pop is impossible by REQ-011.
REQ-021 FIFO pointers SHALL be log2(DEPTH) bits, wrap modulo DEPTH, and full/empty SHALL be derived from outstanding.

Reset
REQ-022 While rst is high at an edge, the block SHALL clear outstanding, FIFO pointers, all pending and slot_valid bits, and id_error; up_rvalid = 0 and dn_arvalid = 0 follow combinationally.
REQ-023 Reset mid-operation SHALL discard all buffered data and in-flight state without emitting any response.
REQ-024 slot data registers SHALL NOT require reset.

Verification
REQ-025 AR ids 1,2,3; slave returns 3(0xC),2(0xB),1(0xA) -> up R delivers 1/0xA, 2/0xB, 3/0xC in that order.
REQ-026 Issue 8 reads with ids 0..7 and up_rready=0 -> outstanding=8 and up_arready=0 for a 9th AR (id 8); one pop -> id 8 accepted the following cycle.
REQ-027 Issue id 5 while id 5 is pending -> up_arready=0 and dn_arvalid=0 until id 5 is delivered.
REQ-028 dn_rvalid with rid 9 never issued -> dn_rready=1, beat dropped, id_error=1, up_rvalid unchanged.
REQ-029 Hold up_rready=0 for 20 cycles with responses buffered -> up_rdata/up_rid stable; release -> one beat per cycle in order.
REQ-030 Assert rst with 3 reads outstanding -> next cycle outstanding=0, up_rvalid=0, id_error=0; new AR id 1 is accepted.
